// File: rtl/div_sequencer_if.sv
// Request/response, shared-ALU and debug-state signals of the divide sequencer.
// slave = the divide unit; master = the pipeline/arbiter side that drives it.
package div_sequencer_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1
    } alu_op_t;
endpackage

interface div_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    import div_sequencer_pkg::*;

    // valid/ready: a transfer happens on a rising edge where both are 1; the
    // sender holds its payload stable while valid=1 and ready=0.
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  busy;
    logic                  alu_req;
    logic                  alu_gnt;
    alu_op_t               alu_op_o;
    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic                  alu_ltu_i;
    logic [1:0]            dbg_state;

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
               alu_gnt, alu_result_i, alu_ltu_i,
        output req_ready, resp_valid, resp_data, busy,
               alu_req, alu_op_o, alu_a_o, alu_b_o, dbg_state
    );

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
               alu_gnt, alu_result_i, alu_ltu_i,
        input  req_ready, resp_valid, resp_data, busy,
               alu_req, alu_op_o, alu_a_o, alu_b_o, dbg_state
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit; one restoring step per granted cycle on the shared ALU.
// Build option DIV_EARLY_OUT_EN: adds a private |a|<|b| comparator that finishes such requests in IDLE.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [DW-1:0]   rem_q;
    logic [DW-1:0]   quo_q;
    logic [DW-1:0]   dvs_q;
    logic [DW-1:0]   resp_q;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic            neg_q;
    logic            neg_r;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            ovf;
    logic            early;
    logic            special;
    logic            accept;
    logic            carry;
    logic            take;
    logic [DW-1:0]   abs_a;
    logic [DW-1:0]   abs_b;
    logic [DW-1:0]   special_data;
    logic [DW-1:0]   shifted;
    logic [DW-1:0]   quo_fix;
    logic [DW-1:0]   rem_fix;

    // Request decode: magnitudes and the cases that finish without iterating.
    always_comb begin
        is_signed = ~bus.req_op[0];
        a_neg     = is_signed & bus.req_a[DW-1];
        b_neg     = is_signed & bus.req_b[DW-1];
        abs_a     = a_neg ? -bus.req_a : bus.req_a;
        abs_b     = b_neg ? -bus.req_b : bus.req_b;
        div_zero  = (bus.req_b == '0);
        ovf       = is_signed && (bus.req_a == MIN_NEG) && (bus.req_b == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = ~div_zero & ~ovf & (abs_a < abs_b);
`else
        early     = 1'b0;
`endif
        special   = div_zero | ovf | early;
        special_data = '0;
        if (div_zero) begin
            special_data = bus.req_op[1] ? bus.req_a : '1;
        end else if (ovf) begin
            special_data = bus.req_op[1] ? '0 : bus.req_a;
        end else if (early) begin
            special_data = bus.req_op[1] ? bus.req_a : '0;
        end
    end

    // One restoring step: carry-out of the shift means S already exceeds the divisor.
    always_comb begin
        carry   = rem_q[DW-1];
        shifted = {rem_q[DW-2:0], quo_q[DW-1]};
        take    = carry | ~bus.alu_ltu_i;
        quo_fix = neg_q ? -quo_q : quo_q;
        rem_fix = neg_r ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b1;
        bus.alu_req    = 1'b0;
        bus.alu_op_o   = ALU_ADD;
        bus.alu_a_o    = '0;
        bus.alu_b_o    = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    state_nx = special ? DONE : ITER;
                end
            end
            ITER: begin
                bus.alu_req  = 1'b1;
                bus.alu_op_o = ALU_SUB;
                bus.alu_a_o  = shifted;
                bus.alu_b_o  = dvs_q;
                if (bus.alu_gnt && (cnt == LAST)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            resp_q <= '0;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= bus.req_op;
                cnt   <= '0;
                rem_q <= '0;
                quo_q <= abs_a;
                dvs_q <= abs_b;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (special) begin
                    resp_q <= special_data;
                end
            end
            // An ungranted ITER cycle leaves every register untouched.
            if ((state == ITER) && bus.alu_gnt) begin
                cnt <= cnt + CW'(1);
                if (take) begin
                    rem_q <= bus.alu_result_i;
                    quo_q <= {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_q <= shifted;
                    quo_q <= {quo_q[DW-2:0], 1'b0};
                end
            end
            if (state == FIX) begin
                resp_q <= op_q[1] ? rem_fix : quo_fix;
            end
        end
    end

    assign bus.resp_data = resp_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: models the shared ALU, scores results against a reference divider.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [W-1:0] exp_q[$];

    div_sequencer_if #(.DATA_WIDTH(W)) bus();

    div_sequencer #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Shared execute ALU, seen by the unit only through these two results.
    assign bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
    assign bus.alu_ltu_i    = (bus.alu_a_o < bus.alu_b_o);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) return op[1] ? a : '1;
        if (!op[0] && a == MIN_NEG && b == '1) return op[1] ? '0 : a;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // ---------------- driver tasks (all start and end at a falling edge) ----------------
    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.alu_gnt    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int n = 0;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    // mode 0: grant every cycle; 1: grant alternates starting with 0; 2: random grant.
    // lat counts rising edges from the accept edge (inclusive) to resp_valid.
    task automatic wait_resp(input int mode, output int lat, output bit to);
        int k = 0;
        lat = 1;
        to  = 1'b0;
        while (!bus.resp_valid) begin
            if (lat > 300) begin
                to = 1'b1;
                break;
            end
            case (mode)
                0:       bus.alu_gnt = 1'b1;
                1:       bus.alu_gnt = k[0];
                default: bus.alu_gnt = 1'($urandom_range(0, 1));
            endcase
            k++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        bus.alu_gnt = 1'b0;
    endtask

    task automatic retire();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                          output logic [W-1:0] data, output int lat, output bit to);
        bit ok;
        send_req(op, a, b, ok);
        to   = !ok;
        lat  = 0;
        data = '0;
        if (ok) begin
            wait_resp(mode, lat, to);
            data = bus.resp_data;
            if (!to) retire();
        end
        if (to) do_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.busy, bus.alu_req} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags got rdy/vld/busy/areq=%b want 1000",
                     {bus.req_ready, bus.resp_valid, bus.busy, bus.alu_req});
        end
        n_cmp++;
        if (bus.resp_data !== '0) begin
            n_err++;
            $display("FAIL reset_resp_data got %h want 0", bus.resp_data);
        end
        n_cmp++;
        if (bus.alu_op_o !== ALU_ADD || bus.alu_a_o !== '0 || bus.alu_b_o !== '0) begin
            n_err++;
            $display("FAIL reset_alu_idle got op=%0d a=%h b=%h want ADD/0/0", bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
        end
    endtask

    task automatic test_unsigned();
        logic [1:0]   ops[4];
        logic [W-1:0] as[4];
        logic [W-1:0] bs[4];
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int lat;
        bit to;
        ops = '{2'd1, 2'd3, 2'd1, 2'd3};
        as  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'h1234_5678};
        bs  = '{32'd7, 32'd7, 32'd1, 32'h100};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model(ops[i], as[i], bs[i]));
            run_op(ops[i], as[i], bs[i], 0, data, lat, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (to || data !== exp) begin
                n_err++;
                $display("FAIL unsigned[%0d] data got %h want %h (timeout=%0d)", i, data, exp, to);
            end
            n_cmp++;
            if (lat !== W + 2) begin
                n_err++;
                $display("FAIL unsigned[%0d] latency got %0d want %0d", i, lat, W + 2);
            end
        end
    endtask

    task automatic test_signed();
        logic [1:0]   ops[6];
        logic [W-1:0] as[6];
        logic [W-1:0] bs[6];
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int lat;
        bit to;
        ops = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2};
        as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
        bs  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd3};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model(ops[i], as[i], bs[i]));
            run_op(ops[i], as[i], bs[i], 0, data, lat, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (to || data !== exp) begin
                n_err++;
                $display("FAIL signed[%0d] data got %h want %h (timeout=%0d)", i, data, exp, to);
            end
            n_cmp++;
            if (lat !== W + 2) begin
                n_err++;
                $display("FAIL signed[%0d] latency got %0d want %0d", i, lat, W + 2);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]   ops[6];
        logic [W-1:0] as[6];
        logic [W-1:0] bs[6];
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int lat;
        bit to;
        ops = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3};
        as  = '{32'd5, 32'd5, MIN_NEG, MIN_NEG, 32'hFFFF_FFF0, 32'd0};
        bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model(ops[i], as[i], bs[i]));
            run_op(ops[i], as[i], bs[i], 0, data, lat, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (to || data !== exp) begin
                n_err++;
                $display("FAIL special[%0d] data got %h want %h (timeout=%0d)", i, data, exp, to);
            end
            n_cmp++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL special[%0d] latency got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_carry_stall();
        logic [1:0]   ops[2];
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int lat;
        bit to;
        ops = '{2'd1, 2'd3};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(ops[i], 32'hFFFF_FFFF, 32'h8000_0001));
            run_op(ops[i], 32'hFFFF_FFFF, 32'h8000_0001, 1, data, lat, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (to || data !== exp) begin
                n_err++;
                $display("FAIL carry_stall[%0d] data got %h want %h (timeout=%0d)", i, data, exp, to);
            end
            n_cmp++;
            if (lat !== 2 * W + 2) begin
                n_err++;
                $display("FAIL carry_stall[%0d] latency got %0d want %0d", i, lat, 2 * W + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        int lat;
        bit ok;
        bit to;
        exp_q.push_back(model(2'd1, 32'd1000, 32'd10));
        send_req(2'd1, 32'd1000, 32'd10, ok);
        lat = 0;
        to  = !ok;
        if (ok) wait_resp(0, lat, to);
        exp = exp_q.pop_front();
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL backpressure response timeout (accepted=%0d)", ok);
            do_reset();
            return;
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) n_cmp++;
            if ({bus.resp_valid, bus.req_ready} !== 2'b10 || bus.resp_data !== exp) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d] got vld/rdy=%b data=%h want 10 data=%h",
                         i, {bus.resp_valid, bus.req_ready}, bus.resp_data, exp);
            end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_retire_cycle req_ready got %b want 0", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL backpressure_after_retire got rdy/vld=%b want 10", {bus.req_ready, bus.resp_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int lat;
        int exp_lat;
        int seen;
        bit ok;
        bit to;
        send_req(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, ok);
        n_cmp++;
        if (!ok || {bus.busy, bus.alu_req} !== 2'b11 || bus.alu_op_o !== ALU_SUB || bus.alu_b_o !== 32'h1234) begin
            n_err++;
            $display("FAIL iter_alu_drive got acc=%0d busy/areq=%b op=%0d b=%h want 1 11 SUB 00001234",
                     ok, {bus.busy, bus.alu_req}, bus.alu_op_o, bus.alu_b_o);
        end
        bus.alu_gnt = 1'b1;
        repeat (10) @(negedge clk);
        rst         = 1'b1;
        bus.alu_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.alu_req, bus.req_ready, bus.resp_valid} !== 4'b0010 || bus.resp_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset got busy/areq/rdy/vld=%b data=%h want 0010 data=0",
                     {bus.busy, bus.alu_req, bus.req_ready, bus.resp_valid}, bus.resp_data);
        end
        seen = 0;
        bus.alu_gnt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        bus.alu_gnt = 1'b0;
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL mid_reset_no_resp got %0d resp_valid cycles want 0", seen);
        end
        exp_q.push_back(model(2'd1, 32'd9, 32'd3));
        run_op(2'd1, 32'd9, 32'd3, 0, data, lat, to);
        exp = exp_q.pop_front();
        n_cmp++;
        if (to || data !== exp || lat !== W + 2) begin
            n_err++;
            $display("FAIL after_reset_divu data got %h want %h latency got %0d want %0d", data, exp, lat, W + 2);
        end
`ifdef DIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = W + 2;
`endif
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(i == 0 ? 2'd1 : 2'd3, 32'd3, 32'd9));
            run_op(i == 0 ? 2'd1 : 2'd3, 32'd3, 32'd9, 0, data, lat, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (to || data !== exp || lat !== exp_lat) begin
                n_err++;
                $display("FAIL small_dividend[%0d] data got %h want %h latency got %0d want %0d",
                         i, data, exp, lat, exp_lat);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int lat;
        int r;
        bit to;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? MIN_NEG : W'($urandom);
            r  = $urandom_range(0, 6);
            case (r)
                0:       b = '0;
                1:       b = '1;
                2, 3:    b = W'($urandom_range(1, 1000));
                default: b = W'($urandom);
            endcase
            exp_q.push_back(model(op, a, b));
            run_op(op, a, b, 2, data, lat, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (to || data !== exp) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h data got %h want %h (timeout=%0d)",
                         i, op, a, b, data, exp, to);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        bus.alu_gnt    = 1'b0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_carry_stall();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
